// File: rtl/normalize_sched.sv
// Time-multiplexed HOG block normalizer: sums 36 bins, streams bin/sum pairs through one shared
// div+sqrt unit and gathers results in order. Optional NORMALIZE_SCHED_ZERO_BYPASS_EN skips zero blocks.
module normalize_sched #(
  parameter int unsigned BIN_I    = 16,
  parameter int unsigned BIN_F    = 16,
  parameter int unsigned FEA_I    = 4,
  parameter int unsigned FEA_F    = 28,
  parameter int unsigned BID_W    = 13,
  parameter int unsigned MAX_BID  = 4660,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             i_valid,
  output logic                             i_ready,
  input  logic [9*(BIN_I+BIN_F)-1:0]       bin_a,
  input  logic [9*(BIN_I+BIN_F)-1:0]       bin_b,
  input  logic [9*(BIN_I+BIN_F)-1:0]       bin_c,
  input  logic [9*(BIN_I+BIN_F)-1:0]       bin_d,
  output logic                             u_valid,
  output logic [BIN_I+BIN_F-1:0]           u_dividend,
  output logic [BIN_I+BIN_F+5:0]           u_divisor,
  input  logic [FEA_I+FEA_F-1:0]           u_result,
  output logic [9*(FEA_I+FEA_F)-1:0]       fea_a,
  output logic [9*(FEA_I+FEA_F)-1:0]       fea_b,
  output logic [9*(FEA_I+FEA_F)-1:0]       fea_c,
  output logic [9*(FEA_I+FEA_F)-1:0]       fea_d,
  output logic [BID_W-1:0]                 bid,
  output logic                             o_valid,
  input  logic                             o_ready
);

  localparam int unsigned BinW  = BIN_I + BIN_F;
  localparam int unsigned SumW  = BinW + 6;
  localparam int unsigned FeaW  = FEA_I + FEA_F;
  localparam int unsigned NBins = 36;

  typedef enum logic [2:0] {StIdle, StSum, StIssue, StDrain, StOut} state_e;

  state_e               state_q;
  logic [BinW-1:0]      bin_q [NBins];
  logic [FeaW-1:0]      fea_q [NBins];
  logic [SumW-1:0]      sum_q;
  logic [1:0]           cell_q;
  logic [5:0]           k_q;
  logic [5:0]           r_q;
  logic [PIPE_LAT-1:0]  mark_q;
  logic                 i_ready_q;
  logic                 o_valid_q;
  logic                 u_valid_q;
  logic [BinW-1:0]      u_dividend_q;
  logic [SumW-1:0]      u_divisor_q;
  logic [BID_W-1:0]     bid_q;

  logic [SumW-1:0]      cell_sum;
  logic [SumW-1:0]      sum_next;
  logic                 capture;

  always_comb begin
    cell_sum = '0;
    for (int k = 0; k < 36; k++) begin
      if (k / 9 == int'(cell_q)) cell_sum = cell_sum + SumW'(bin_q[k]);
    end
    sum_next = sum_q + cell_sum;
  end

  // Oldest mark lines up with the unit's result for the matching issue.
  assign capture = mark_q[PIPE_LAT-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      sum_q        <= '0;
      cell_q       <= '0;
      k_q          <= '0;
      r_q          <= '0;
      mark_q       <= '0;
      i_ready_q    <= 1'b1;
      o_valid_q    <= 1'b0;
      u_valid_q    <= 1'b0;
      u_dividend_q <= '0;
      u_divisor_q  <= '0;
      bid_q        <= '0;
      for (int k = 0; k < 36; k++) fea_q[k] <= '0;
    end else begin
      mark_q <= (mark_q << 1) | PIPE_LAT'(u_valid_q);
      if (capture && r_q < 6'd36) begin
        fea_q[r_q] <= u_result;
        r_q        <= r_q + 6'd1;
      end

      if (clear) begin
        bid_q <= '0;
      end else if (o_valid_q && o_ready) begin
        bid_q <= (bid_q == BID_W'(MAX_BID)) ? '0 : bid_q + BID_W'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            for (int k = 0; k < 9; k++) begin
              bin_q[k]      <= bin_a[k*BinW +: BinW];
              bin_q[9 + k]  <= bin_b[k*BinW +: BinW];
              bin_q[18 + k] <= bin_c[k*BinW +: BinW];
              bin_q[27 + k] <= bin_d[k*BinW +: BinW];
            end
            sum_q     <= '0;
            cell_q    <= '0;
            i_ready_q <= 1'b0;
            state_q   <= StSum;
          end
        end
        StSum: begin
          sum_q  <= sum_next;
          cell_q <= cell_q + 2'd1;
          if (cell_q == 2'd3) begin
            u_valid_q    <= 1'b1;
            u_dividend_q <= bin_q[0];
            u_divisor_q  <= sum_next;
            k_q          <= '0;
            state_q      <= StIssue;
`ifdef NORMALIZE_SCHED_ZERO_BYPASS_EN
            if (sum_next == '0) begin
              u_valid_q <= 1'b0;
              for (int k = 0; k < 36; k++) fea_q[k] <= '0;
              o_valid_q <= 1'b1;
              state_q   <= StOut;
            end
`endif
          end
        end
        StIssue: begin
          if (k_q == 6'd35) begin
            u_valid_q <= 1'b0;
            state_q   <= StDrain;
          end else begin
            k_q          <= k_q + 6'd1;
            u_dividend_q <= bin_q[k_q + 6'd1];
          end
        end
        StDrain: begin
          if (capture && r_q == 6'd35) begin
            o_valid_q <= 1'b1;
            state_q   <= StOut;
          end
        end
        StOut: begin
          if (o_ready) begin
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
            r_q       <= '0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Feature 0 of each cell sits in the MSBs.
  always_comb begin
    fea_a = '0;
    fea_b = '0;
    fea_c = '0;
    fea_d = '0;
    for (int j = 0; j < 9; j++) begin
      fea_a[(8-j)*FeaW +: FeaW] = fea_q[j];
      fea_b[(8-j)*FeaW +: FeaW] = fea_q[9 + j];
      fea_c[(8-j)*FeaW +: FeaW] = fea_q[18 + j];
      fea_d[(8-j)*FeaW +: FeaW] = fea_q[27 + j];
    end
  end

  assign i_ready    = i_ready_q;
  assign o_valid    = o_valid_q;
  assign u_valid    = u_valid_q;
  assign u_dividend = u_dividend_q;
  assign u_divisor  = u_divisor_q;
  assign bid        = bid_q;

endmodule

// File: tb/tb_normalize_sched.sv
// Directed bench for normalize_sched with a PIPE_LAT-deep model of the shared div+sqrt unit.
module tb_normalize_sched;

  localparam int unsigned PL   = 4;
  localparam int unsigned MAXB = 11;  // short wrap period keeps run time bounded
`ifdef NORMALIZE_SCHED_ZERO_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         i_valid;
  logic         i_ready;
  logic [287:0] bin_a, bin_b, bin_c, bin_d;
  logic         u_valid;
  logic [31:0]  u_dividend;
  logic [37:0]  u_divisor;
  logic [31:0]  u_result;
  logic [287:0] fea_a, fea_b, fea_c, fea_d;
  logic [12:0]  bid;
  logic         o_valid;
  logic         o_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_bin [36];
  logic [31:0] exp_f   [36];
  logic [37:0] exp_sum;
  logic [31:0] pipe_q  [PL];

  always #5 clk = ~clk;

  normalize_sched #(
    .MAX_BID  (MAXB),
    .PIPE_LAT (PL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .bin_a      (bin_a),
    .bin_b      (bin_b),
    .bin_c      (bin_c),
    .bin_d      (bin_d),
    .u_valid    (u_valid),
    .u_dividend (u_dividend),
    .u_divisor  (u_divisor),
    .u_result   (u_result),
    .fea_a      (fea_a),
    .fea_b      (fea_b),
    .fea_c      (fea_c),
    .fea_d      (fea_d),
    .bid        (bid),
    .o_valid    (o_valid),
    .o_ready    (o_ready)
  );

  // Unit model: 1.0/36.0 gives sqrt(1/36) in 4.28; anything else returns a dividend-derived tag.
  function automatic logic [31:0] unit_f(input logic [31:0] dv, input logic [37:0] ds);
    if (dv == 32'h0001_0000 && ds == 38'h24_0000) return 32'h02AA_AAAA;
    return dv + 32'h0000_1234;
  endfunction

  always @(posedge clk) begin
    pipe_q[0] <= unit_f(u_dividend, u_divisor);
    for (int i = 1; i < PL; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign u_result = pipe_q[PL-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_fea(input int k);
    int j;
    j = k % 9;
    case (k / 9)
      0:       return fea_a[(8-j)*32 +: 32];
      1:       return fea_b[(8-j)*32 +: 32];
      2:       return fea_c[(8-j)*32 +: 32];
      default: return fea_d[(8-j)*32 +: 32];
    endcase
  endfunction

  // mode 0: all 1.0, mode 1: bin k = k, mode 2: all zero
  task automatic load(input int mode);
    exp_sum = '0;
    for (int k = 0; k < 36; k++) begin
      case (mode)
        0:       exp_bin[k] = 32'h0001_0000;
        1:       exp_bin[k] = k << 16;
        default: exp_bin[k] = '0;
      endcase
      exp_sum = exp_sum + 38'(exp_bin[k]);
    end
    for (int k = 0; k < 36; k++) begin
      case (mode)
        0:       exp_f[k] = 32'h02AA_AAAA;
        1:       exp_f[k] = (k << 16) + 32'h1234;
        default: exp_f[k] = Bypass ? 32'h0 : 32'h1234;
      endcase
    end
    for (int k = 0; k < 9; k++) begin
      bin_a[k*32 +: 32] = exp_bin[k];
      bin_b[k*32 +: 32] = exp_bin[9 + k];
      bin_c[k*32 +: 32] = exp_bin[18 + k];
      bin_d[k*32 +: 32] = exp_bin[27 + k];
    end
  endtask

  task automatic run_block(input int exp_uv, input int exp_ov, input logic [12:0] exp_bid,
                           input int hold, input bit do_clr);
    int uv;
    int ov;
    logic [12:0] nb;
    uv = 0;
    ov = 0;
    o_ready = (hold == 0);
    chk("accept_ready", i_ready, 1);
    i_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 120 && ov == 0; c++) begin
      @(negedge clk);
      i_valid = 1'b0;
      if (u_valid) begin
        if (uv < 36) chk("u_dividend", u_dividend, exp_bin[uv]);
        chk("u_divisor", u_divisor, exp_sum);
        uv++;
      end
      if (o_valid) ov = c;
    end
    chk("o_valid_cycle", ov, exp_ov);
    chk("u_valid_count", uv, exp_uv);
    if (ov != 0) begin
      chk("bid", bid, exp_bid);
      for (int k = 0; k < 36; k++) chk("feature", get_fea(k), exp_f[k]);
      chk("busy_i_ready", i_ready, 0);
      for (int h = 1; h < hold; h++) begin
        i_valid = 1'b1;
        @(negedge clk);
        chk("hold_o_valid", o_valid, 1);
        chk("hold_i_ready", i_ready, 0);
        chk("hold_bid", bid, exp_bid);
        chk("hold_f0", fea_a[287:256], exp_f[0]);
        chk("hold_f35", fea_d[31:0], exp_f[35]);
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      clear   = do_clr;
      @(negedge clk);
      clear = 1'b0;
      nb = do_clr ? 13'd0 : ((exp_bid == 13'(MAXB)) ? 13'd0 : exp_bid + 13'd1);
      chk("post_hs_o_valid", o_valid, 0);
      chk("post_hs_i_ready", i_ready, 1);
      chk("next_bid", bid, nb);
    end
  endtask

  initial begin
    rst     = 1'b0;
    clear   = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    load(2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_ready", i_ready, 1);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_u_valid", u_valid, 0);
    chk("rst_u_dividend", u_dividend, 0);
    chk("rst_u_divisor", u_divisor, 0);
    chk("rst_bid", bid, 0);
    chk("rst_fea", {fea_a, fea_b, fea_c, fea_d} == '0, 1);
    rst = 1'b1;
    @(negedge clk);

    load(0);
    run_block(36, 45, 13'd0, 0, 1'b0);
    load(1);
    run_block(36, 45, 13'd1, 0, 1'b0);
    load(0);
    run_block(36, 45, 13'd2, 11, 1'b0);
    load(2);
    if (Bypass) run_block(0, 5, 13'd3, 0, 1'b0);
    else        run_block(36, 45, 13'd3, 0, 1'b0);

    load(0);
    for (int b = 4; b <= MAXB; b++) run_block(36, 45, 13'(b), 0, 1'b0);
    for (int b = 0; b < 7; b++) run_block(36, 45, 13'(b), 0, 1'b0);
    run_block(36, 45, 13'd7, 0, 1'b1);
    run_block(36, 45, 13'd0, 0, 1'b0);

    // Reset while issuing k=20 (cycle 25 after accept).
    load(1);
    o_ready = 1'b1;
    i_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      i_valid = 1'b0;
    end
    chk("pre_rst_u_valid", u_valid, 1);
    chk("pre_rst_k20", u_dividend, exp_bin[20]);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_i_ready", i_ready, 1);
    chk("mid_rst_o_valid", o_valid, 0);
    chk("mid_rst_u_valid", u_valid, 0);
    chk("mid_rst_bid", bid, 0);
    repeat (PL + 2) @(negedge clk);
    chk("post_rst_o_valid", o_valid, 0);
    load(0);
    run_block(36, 45, 13'd0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/normalize_sched.md
# normalize_sched

Time-multiplexed sequencer for HOG block normalization. Accepts one 2x2-cell block (36 unsigned fixed-point bins) per handshake, accumulates the L1 sum, then issues the 36 bin/sum pairs one per cycle to a single shared divide+sqrt pipeline. It collects the results in order and presents the 36 features with a block id to the SVM stage. It replaces 36 parallel divider/sqrt instances with one.

## Interface
- BIN_I, 16, integer bits of a bin
- BIN_F, 16, fractional bits of a bin
- FEA_I, 4, integer bits of a feature
- FEA_F, 28, fractional bits of a feature
- BID_W, 13, block id width
- MAX_BID, 4660, last block id before wrap
- PIPE_LAT, 4, fixed latency (cycles) of the external div+sqrt unit, ≥1

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- clear  in  1  synchronous block-id counter reset
- i_valid  in  1  input block valid
- i_ready  out  1  input block accepted when i_valid&&i_ready
- bin_a/b/c/d  in  9*(BIN_I+BIN_F) each  cell bins; bin k of a cell at bits [(k+1)W-1:kW]; global index a:0–8, b:9–17, c:18–26, d:27–35
- u_valid  out  1  operand valid to shared unit
- u_dividend  out  BIN_I+BIN_F  bin being normalized
- u_divisor  out  BIN_I+BIN_F+6  block sum
- u_result  in  FEA_I+FEA_F  sqrt(dividend/divisor), valid PIPE_LAT cycles after u_valid
- fea_a/b/c/d  out  9*(FEA_I+FEA_F) each  features; fea_a = {f0,f1,…,f8}, f0 in MSBs (likewise b: f9…f17, etc.)
- bid  out  BID_W  id of the presented block
- o_valid  out  1  output block valid
- o_ready  in  1  downstream ready

## Operation
- FSM states: IDLE, SUM, ISSUE, DRAIN, OUT.
- IDLE: i_ready=1. On i_valid, register all 36 bins, clear the sum, and go to SUM.
- SUM: 4 cycles. Each cycle adds the 9 bins of one cell (a, b, c, d in that order) into the sum register. The sum is BIN_I+BIN_F+6 bits and never overflows. Then go to ISSUE.
- ISSUE: 36 cycles. Index k runs 0→35. Drive u_valid=1, u_dividend=bin[k], u_divisor=sum. After k=35, go to DRAIN.
- Return path:
  - A PIPE_LAT-deep shift register of u_valid marks result cycles.
  - On each marked cycle, capture u_result into feature slot r, then increment r (0→35).
  - The unit is not stallable; issue never pauses.
- DRAIN: wait until r reaches 36, then go to OUT.
- OUT: o_valid=1. fea_* and bid are held stable until o_ready. On o_valid&&o_ready, go to IDLE and update the bid counter.
- Bid counter:
  - Updates only on an output handshake: if the counter equals MAX_BID, it wraps to 0; otherwise it increments.
  - clear (any state) forces the counter to 0. If clear and a handshake occur in the same cycle, clear wins (result 0).
  - clear does not abort a block in flight.
- Reset (rst=0), effective at the clock edge from any state: state=IDLE, bid=0, r=0, return shift register cleared. Results still in the external unit are dropped.
- Reset values: i_ready=1, o_valid=0, u_valid=0, u_dividend=0, u_divisor=0, fea_*=0, bid=0.

## Timing
- Accept edge E0, defined as the edge where i_valid&&i_ready.
- SUM spans cycles 1–4 after E0; u_valid is high in cycles 5–40.
- Last result is captured at cycle 40+PIPE_LAT.
- o_valid rises at cycle 41+PIPE_LAT (45 with the default PIPE_LAT).
- i_ready is low from E0 until the cycle after the output handshake. No overlap of blocks.
- Minimum block period is 42+PIPE_LAT cycles when o_ready is held at 1.

## Configuration
- NORMALIZE_SCHED_ZERO_BYPASS_EN defined: if the sum is 0 at the end of SUM, skip ISSUE and DRAIN. All 36 features are set to 0 and OUT is entered next cycle (o_valid at cycle 5 after E0). u_valid stays 0 for that block.
- Not defined: a zero-sum block is issued normally and the unit's returned values are captured unchanged.

## Test plan
- Single block, all bins = 1.0 (0x0001_0000), o_ready=1:
  - sum = 36.0; u_valid high exactly 36 cycles.
  - o_valid at cycle 45 after E0; every feature equals the unit's result for 1/36 (≈0.1667); bid=0.
- Bins 0..35 = integer k, with a unit model returning k tagged per issue: feature slot k carries tag k, confirming order and MSB-first packing.
- o_ready held low 10 cycles in OUT: fea_*/bid stable, i_ready=0, no new accept; handshake on the 11th cycle, then bid=1.
- 4661 blocks back-to-back: bid sequence 0…4660 then 0. clear asserted together with a handshake at bid=7: next bid=0.
- All-zero block:
  - With NORMALIZE_SCHED_ZERO_BYPASS_EN: o_valid at cycle 5, no u_valid pulses, features all 0.
  - Without it: 36 issues with u_divisor=0.
- rst=0 during ISSUE at k=20: next cycle i_ready=1, o_valid=0, u_valid=0. A fresh block then completes normally with bid=0.
